// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions.
//   WORD_W / INSTR_BYTES : datapath word width and instruction size in bytes
//   fetch_state_e        : fetch FSM states
//   fetch_entry_t        : {pc, instr} payload buffered between fetch and decode
//   word_align()         : clear the byte-offset bits of an address
package mips_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with registered storage and a synchronous clear.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : empty the FIFO this cycle (overrides push/pop)
//   i_push       : write i_push_data (ignored when full unless popping)
//   i_pop        : remove the head entry (ignored when empty)
//   o_head       : current head entry
//   o_empty      : no entries held
//   o_full       : DEPTH entries held
//   o_count      : number of entries held
module mips_sync_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointer advance with explicit wrap so non power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// Decoupled instruction-fetch stage: issues sequential word fetches, buffers the
// returned words with their PC and hands them to decode on valid/ready.
// A redirect retargets the fetch PC, clears the buffer and discards responses
// that belong to requests already in flight.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           : fetch request handshake
//   imem_rsp_valid/data                 : in-order fetch responses, never stalled
//   redirect_valid/redirect_pc          : taken branch/jump pulse and target
//   dec_valid/ready, dec_instr/pc/pc_plus4 : buffered instruction to decode
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [WORD_W-1:0] dec_instr,
  output logic [WORD_W-1:0] dec_pc,
  output logic [WORD_W-1:0] dec_pc_plus4
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] w_fetch_pc_nxt;
  logic [OUT_W-1:0]  r_outst;
  logic [OUT_W-1:0]  w_outst_nxt;
  logic [OUT_W-1:0]  r_drop;
  logic [OUT_W-1:0]  w_drop_nxt;
  logic              r_req_valid;
  logic              w_req_valid_nxt;

  logic              w_issue;
  logic              w_rsp_ok;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_data_cnt;
  logic [CNT_W-1:0]  w_data_cnt_nxt;
  logic              w_data_empty;
  logic              w_data_full;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  logic [WORD_W-1:0] w_tag_head;
  logic              w_tag_empty;
  logic              w_tag_full;
  logic [OUT_W-1:0]  w_tag_cnt;

  // Handshake events for this cycle.
  assign w_issue  = r_req_valid & imem_req_ready;
  assign w_rsp_ok = imem_rsp_valid & (r_outst != '0);
  assign w_pop    = dec_valid & dec_ready;
  // Responses are kept only in RUN with nothing left to discard; a response
  // coinciding with a redirect is stale by definition.
  assign w_push   = w_rsp_ok & (r_state == RUN) & (r_drop == '0) & ~redirect_valid;

  assign w_outst_nxt  = r_outst + OUT_W'(w_issue) - OUT_W'(w_rsp_ok);
  assign w_push_entry = '{pc: w_tag_head, instr: imem_rsp_data};

  // Addresses of requests in flight, consumed one per response (kept or dropped).
  mips_sync_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (MAX_OUTST)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (1'b0),
    .i_push      (w_issue),
    .i_push_data (r_fetch_pc),
    .i_pop       (w_rsp_ok),
    .o_head      (w_tag_head),
    .o_empty     (w_tag_empty),
    .o_full      (w_tag_full),
    .o_count     (w_tag_cnt)
  );

  // Fetched {pc, instr} entries awaiting decode.
  mips_sync_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_data_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_data_empty),
    .o_full      (w_data_full),
    .o_count     (w_data_cnt)
  );

  // Buffer occupancy after this cycle, used to precompute next-cycle credit.
  always_comb begin
    if (redirect_valid) begin
      w_data_cnt_nxt = '0;
    end else begin
      w_data_cnt_nxt = w_data_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Next state and discard counter; a redirect overrides the normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    unique case (r_state)
      BOOT:  w_state_nxt = RUN;
      RUN:   w_state_nxt = RUN;
      FLUSH: begin
        if (r_drop == '0) begin
          w_state_nxt = RUN;
        end else if (w_rsp_ok) begin
          w_drop_nxt = r_drop - OUT_W'(1);
          if (r_drop == OUT_W'(1)) begin
            w_state_nxt = RUN;
          end
        end
      end
      default: w_state_nxt = BOOT;
    endcase
    if (redirect_valid) begin
      w_drop_nxt  = w_outst_nxt;
      w_state_nxt = (w_outst_nxt != '0) ? FLUSH : RUN;
    end
  end

  // Fetch PC and registered request-valid. The credit rule reserves a buffer
  // slot for every request in flight, so the data FIFO can never overflow.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect_valid) begin
      w_fetch_pc_nxt = word_align(redirect_pc);
    end else if (w_issue) begin
      w_fetch_pc_nxt = r_fetch_pc + WORD_W'(INSTR_BYTES);
    end
    w_req_valid_nxt = (w_state_nxt == RUN)
                    && (w_outst_nxt < OUT_W'(MAX_OUTST))
                    && ((CRD_W'(w_data_cnt_nxt) + CRD_W'(w_outst_nxt)) < CRD_W'(DEPTH));
  end

  // Fetch-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BOOT;
      r_fetch_pc  <= RESET_PC;
      r_outst     <= '0;
      r_drop      <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_outst     <= w_outst_nxt;
      r_drop      <= w_drop_nxt;
      r_req_valid <= w_req_valid_nxt;
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_fetch_pc;

  // Decode side is driven straight from FIFO registers; zero when empty.
  assign dec_valid    = ~w_data_empty;
  assign dec_instr    = dec_valid ? w_head.instr : '0;
  assign dec_pc       = dec_valid ? w_head.pc : '0;
  assign dec_pc_plus4 = dec_valid ? (w_head.pc + WORD_W'(INSTR_BYTES)) : '0;

  a_rsp_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outst != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (w_push && !w_pop) |-> !w_data_full);
  a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
    w_issue |-> !w_tag_full);
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_ok |-> !w_tag_empty);
  a_tag_track: assert property (@(posedge clk) disable iff (!rst_n)
    w_tag_cnt == r_outst);

endmodule
